// File: rtl/fp_wb_trace_buffer_if.sv
// Bundles the writeback tap, control pulses and host-side trace drain of fp_wb_trace_buffer.
// master drives the stimulus and trace_ready; slave is the trace buffer itself.
interface fp_wb_trace_buffer_if;
    logic        arm;
    logic        halt;
    logic        clear;
    logic        wb_valid_in;
    logic        wb_reg_write_en_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_result_in;
    logic [7:0]  wb_pc_in;
    logic        trace_valid;
    logic        trace_ready;
    logic [54:0] trace_data;
    logic [6:0]  trace_count;
    logic [15:0] drop_count;
    logic [1:0]  state_out;

    modport master (
        output arm, halt, clear, wb_valid_in, wb_reg_write_en_in,
               wb_rd_in, wb_result_in, wb_pc_in, trace_ready,
        input  trace_valid, trace_data, trace_count, drop_count, state_out
    );

    modport slave (
        input  arm, halt, clear, wb_valid_in, wb_reg_write_en_in,
               wb_rd_in, wb_result_in, wb_pc_in, trace_ready,
        output trace_valid, trace_data, trace_count, drop_count, state_out
    );
endinterface

// File: rtl/fp_wb_trace_buffer.sv
// Captures FP writeback events into a trace FIFO; a record is visible one cycle after capture.
// Host drains with valid/ready; a full FIFO drops the event (and freezes when STOP_ON_FULL).
module fp_wb_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_wb_trace_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_CAPTURE = 2'b01;
    localparam logic [1:0] S_FROZEN  = 2'b10;

    logic [1:0]  r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_seq;
    logic [15:0] r_drop_cnt;
    logic [54:0] r_mem [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_event;
    logic        w_push;
    logic        w_drop;
    logic [1:0]  w_class;
    logic [AW:0] w_occupancy;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && bus.trace_ready;

    // clear/halt win over a coincident event, so it is never recorded
    assign w_event = (r_state == S_CAPTURE) && bus.wb_valid_in && bus.wb_reg_write_en_in &&
                     !bus.clear && !bus.halt;
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    always_comb begin
        w_class = 2'b00;
        if (bus.wb_result_in[30:23] == 8'hFF) begin
            w_class = (bus.wb_result_in[22:0] != 23'd0) ? 2'b11 : 2'b10;
        end else if (bus.wb_result_in[30:0] == 31'd0) begin
            w_class = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_seq      <= 8'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_seq    <= r_seq + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.arm) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (bus.halt)                      r_state <= S_IDLE;
                    else if (w_drop && STOP_ON_FULL)   r_state <= S_FROZEN;
                end
                S_FROZEN: r_state <= S_FROZEN;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {r_seq, w_class, bus.wb_pc_in, bus.wb_rd_in, bus.wb_result_in};
        end
    end

    assign w_occupancy     = r_wr_ptr - r_rd_ptr;
    assign bus.trace_valid = !w_empty;
    // stale storage is masked so an empty FIFO always presents zero
    assign bus.trace_data  = w_empty ? 55'd0 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.trace_count = 7'(w_occupancy);
    assign bus.drop_count  = r_drop_cnt;
    assign bus.state_out   = r_state;
endmodule

// File: tb/tb_fp_wb_trace_buffer.sv
// Directed bench for fp_wb_trace_buffer: DUT a freezes on overflow, DUT b keeps capturing.
module tb_fp_wb_trace_buffer;
    logic        clk;
    logic        reset;
    logic        arm, halt, clear, wv, we, ready;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [7:0]  pc;
    logic [54:0] exp_rec;
    int          vectors;
    int          miscompares;

    fp_wb_trace_buffer_if bus_a ();
    fp_wb_trace_buffer_if bus_b ();

    assign bus_a.arm = arm;                 assign bus_b.arm = arm;
    assign bus_a.halt = halt;               assign bus_b.halt = halt;
    assign bus_a.clear = clear;             assign bus_b.clear = clear;
    assign bus_a.wb_valid_in = wv;          assign bus_b.wb_valid_in = wv;
    assign bus_a.wb_reg_write_en_in = we;   assign bus_b.wb_reg_write_en_in = we;
    assign bus_a.wb_rd_in = rd;             assign bus_b.wb_rd_in = rd;
    assign bus_a.wb_result_in = res;        assign bus_b.wb_result_in = res;
    assign bus_a.wb_pc_in = pc;             assign bus_b.wb_pc_in = pc;
    assign bus_a.trace_ready = ready;       assign bus_b.trace_ready = ready;

    fp_wb_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    fp_wb_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ev(input logic [4:0] r, input logic [31:0] v, input logic [7:0] p);
        wv = 1'b1; we = 1'b1; rd = r; res = v; pc = p;
    endtask

    task automatic idle_in;
        wv = 1'b0; we = 1'b0;
    endtask

    task automatic pulse_arm;
        arm = 1'b1; tick; arm = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1; arm = 0; halt = 0; clear = 0; ready = 0;
        idle_in; rd = 0; res = 0; pc = 0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        vectors++; if (bus_a.state_out !== 2'b00) begin miscompares++; $display("FAIL reset_state got %b want 00", bus_a.state_out); end
        vectors++; if (bus_a.trace_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus_a.trace_valid); end
        vectors++; if (bus_a.trace_count !== 7'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus_a.trace_count); end
        vectors++; if (bus_a.drop_count !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", bus_a.drop_count); end
        vectors++; if (bus_a.trace_data !== 55'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus_a.trace_data); end
    endtask

    task automatic test_basic;
        do_reset;
        ready = 1'b1;
        pulse_arm;
        vectors++; if (bus_a.state_out !== 2'b01) begin miscompares++; $display("FAIL arm_state got %b want 01", bus_a.state_out); end
        drive_ev(5'd3, 32'h40490FD0, 8'h00);
        tick;
        exp_rec = {8'h00, 2'b00, 8'h00, 5'd3, 32'h40490FD0};
        vectors++; if (bus_a.trace_valid !== 1'b1 || bus_a.trace_data !== exp_rec) begin miscompares++; $display("FAIL basic_rec0 got v=%b %h want v=1 %h", bus_a.trace_valid, bus_a.trace_data, exp_rec); end
        drive_ev(5'd20, 32'h7F800000, 8'h2C);
        tick;
        exp_rec = {8'h01, 2'b10, 8'h2C, 5'd20, 32'h7F800000};
        vectors++; if (bus_a.trace_valid !== 1'b1 || bus_a.trace_data !== exp_rec) begin miscompares++; $display("FAIL basic_rec1 got v=%b %h want v=1 %h", bus_a.trace_valid, bus_a.trace_data, exp_rec); end
        vectors++; if (bus_a.trace_count !== 7'd1) begin miscompares++; $display("FAIL basic_count got %0d want 1", bus_a.trace_count); end
        idle_in;
        tick;
        vectors++; if (bus_a.trace_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drained got %b want 0", bus_a.trace_valid); end
    endtask

    task automatic test_class;
        drive_ev(5'd1, 32'h7FC00000, 8'h01);
        tick;
        vectors++; if (bus_a.trace_data[54:45] !== {8'd2, 2'b11}) begin miscompares++; $display("FAIL class_nan got %h want seq 2 class 3", bus_a.trace_data[54:45]); end
        drive_ev(5'd2, 32'h80000000, 8'h02);
        tick;
        vectors++; if (bus_a.trace_data[54:45] !== {8'd3, 2'b01}) begin miscompares++; $display("FAIL class_zero got %h want seq 3 class 1", bus_a.trace_data[54:45]); end
        idle_in;
        tick;
    endtask

    task automatic test_full_freeze;
        do_reset;
        pulse_arm;
        for (int i = 0; i < 17; i++) begin
            drive_ev(5'(i), 32'h3F800000 + 32'(i), 8'(i));
            tick;
        end
        idle_in;
        vectors++; if (bus_a.trace_count !== 7'd16) begin miscompares++; $display("FAIL freeze_count got %0d want 16", bus_a.trace_count); end
        vectors++; if (bus_a.drop_count !== 16'd1) begin miscompares++; $display("FAIL freeze_drop got %0d want 1", bus_a.drop_count); end
        vectors++; if (bus_a.state_out !== 2'b10) begin miscompares++; $display("FAIL freeze_state got %b want 10", bus_a.state_out); end
        drive_ev(5'd30, 32'h0, 8'hEE);
        tick; tick;
        idle_in;
        vectors++; if (bus_a.trace_count !== 7'd16 || bus_a.drop_count !== 16'd1) begin miscompares++; $display("FAIL frozen_ignore got cnt=%0d drop=%0d want 16/1", bus_a.trace_count, bus_a.drop_count); end
        vectors++; if (bus_b.drop_count !== 16'd3 || bus_b.state_out !== 2'b01) begin miscompares++; $display("FAIL nostop_drop got drop=%0d st=%b want 3/01", bus_b.drop_count, bus_b.state_out); end
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_rec = {8'(i), 2'b00, 8'(i), 5'(i), 32'h3F800000 + 32'(i)};
            vectors++; if (bus_a.trace_valid !== 1'b1 || bus_a.trace_data !== exp_rec) begin miscompares++; $display("FAIL drain_rec%0d got v=%b %h want %h", i, bus_a.trace_valid, bus_a.trace_data, exp_rec); end
            tick;
        end
        vectors++; if (bus_a.trace_count !== 7'd0 || bus_a.state_out !== 2'b10) begin miscompares++; $display("FAIL drain_end got cnt=%0d st=%b want 0/10", bus_a.trace_count, bus_a.state_out); end
        clear = 1'b1; tick; clear = 1'b0;
        vectors++; if (bus_a.state_out !== 2'b00 || bus_a.drop_count !== 16'd0) begin miscompares++; $display("FAIL unfreeze got st=%b drop=%0d want 00/0", bus_a.state_out, bus_a.drop_count); end
    endtask

    task automatic test_push_pop_full;
        do_reset;
        pulse_arm;
        for (int i = 0; i < 16; i++) begin
            drive_ev(5'(i), 32'h3F800000, 8'(i));
            tick;
        end
        vectors++; if (bus_b.trace_count !== 7'd16 || bus_b.drop_count !== 16'd0) begin miscompares++; $display("FAIL pp_fill got cnt=%0d drop=%0d want 16/0", bus_b.trace_count, bus_b.drop_count); end
        drive_ev(5'd9, 32'h12345678, 8'h99);
        ready = 1'b1;
        tick;
        idle_in;
        vectors++; if (bus_b.trace_count !== 7'd16 || bus_b.drop_count !== 16'd0) begin miscompares++; $display("FAIL pp_count got cnt=%0d drop=%0d want 16/0", bus_b.trace_count, bus_b.drop_count); end
        vectors++; if (bus_b.trace_data[54:47] !== 8'd1) begin miscompares++; $display("FAIL pp_head got seq %0d want 1", bus_b.trace_data[54:47]); end
        for (int i = 0; i < 15; i++) tick;
        exp_rec = {8'd16, 2'b00, 8'h99, 5'd9, 32'h12345678};
        vectors++; if (bus_b.trace_valid !== 1'b1 || bus_b.trace_data !== exp_rec) begin miscompares++; $display("FAIL pp_newrec got v=%b %h want %h", bus_b.trace_valid, bus_b.trace_data, exp_rec); end
        tick;
        vectors++; if (bus_b.trace_valid !== 1'b0) begin miscompares++; $display("FAIL pp_empty got %b want 0", bus_b.trace_valid); end
    endtask

    task automatic test_clear_halt;
        do_reset;
        pulse_arm;
        drive_ev(5'd3, 32'h0, 8'h10);
        tick;
        vectors++; if (bus_a.trace_count !== 7'd1) begin miscompares++; $display("FAIL ch_pre got %0d want 1", bus_a.trace_count); end
        drive_ev(5'd4, 32'h3F800000, 8'h11);
        clear = 1'b1; halt = 1'b1;
        tick;
        clear = 1'b0; halt = 1'b0; idle_in;
        vectors++; if (bus_a.state_out !== 2'b00 || bus_a.trace_count !== 7'd0 || bus_a.trace_data !== 55'd0) begin miscompares++; $display("FAIL ch_clear got st=%b cnt=%0d d=%h want 00/0/0", bus_a.state_out, bus_a.trace_count, bus_a.trace_data); end
        pulse_arm;
        drive_ev(5'd5, 32'h3F800000, 8'h12);
        halt = 1'b1;
        tick;
        halt = 1'b0; idle_in;
        vectors++; if (bus_a.state_out !== 2'b00 || bus_a.trace_count !== 7'd0) begin miscompares++; $display("FAIL ch_halt got st=%b cnt=%0d want 00/0", bus_a.state_out, bus_a.trace_count); end
        drive_ev(5'd6, 32'h3F800000, 8'h13);
        tick;
        idle_in;
        vectors++; if (bus_a.trace_count !== 7'd0 || bus_a.drop_count !== 16'd0) begin miscompares++; $display("FAIL ch_idle_ev got cnt=%0d drop=%0d want 0/0", bus_a.trace_count, bus_a.drop_count); end
    endtask

    task automatic test_back_to_back_wrap;
        do_reset;
        ready = 1'b1;
        pulse_arm;
        for (int k = 0; k < 300; k++) begin
            drive_ev(5'(k), 32'h3F800000, 8'(k));
            tick;
            vectors++; if (bus_a.trace_valid !== 1'b1 || bus_a.trace_data[54:47] !== 8'(k)) begin miscompares++; $display("FAIL wrap_seq%0d got v=%b seq %0d want %0d", k, bus_a.trace_valid, bus_a.trace_data[54:47], k % 256); end
        end
        idle_in;
        tick;
        vectors++; if (bus_a.drop_count !== 16'd0 || bus_a.trace_count !== 7'd0 || bus_a.state_out !== 2'b01) begin miscompares++; $display("FAIL wrap_end got drop=%0d cnt=%0d st=%b want 0/0/01", bus_a.drop_count, bus_a.trace_count, bus_a.state_out); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_class;
        test_full_freeze;
        test_push_pop_full;
        test_clear_halt;
        test_back_to_back_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fp_wb_trace_buffer.md
FP_WB_TRACE_BUFFER -- requirements
Module: fp_wb_trace_buffer

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 16, meaning trace FIFO entries (power of two, 4..64).
REQ-002 The block SHALL provide parameter STOP_ON_FULL, default 1, meaning 1 = freeze capture on overflow and 0 = drop new events and keep capturing.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arm  input  1  one-cycle pulse that starts capture.
REQ-006 halt  input  1  one-cycle pulse that stops capture.
REQ-007 clear  input  1  one-cycle pulse that empties the FIFO, zeroes the counters and returns to IDLE.
REQ-008 wb_valid_in  input  1  writeback-stage valid.
REQ-009 wb_reg_write_en_in  input  1  writeback register-write enable.
REQ-010 wb_rd_in  input  5  destination register index.
REQ-011 wb_result_in  input  32  IEEE754 single-precision result.
REQ-012 wb_pc_in  input  8  PC of the retiring instruction.
REQ-013 trace_valid  output  1  FIFO head record is valid.
REQ-014 trace_ready  input  1  host accepts the head record.
REQ-015 trace_data  output  55  record {seq[7:0], class[1:0], pc[7:0], rd[4:0], result[31:0]}.
REQ-016 trace_count  output  7  current FIFO occupancy.
REQ-017 drop_count  output  16  events lost to a full FIFO; saturates at 0xFFFF.
REQ-018 state_out  output  2  FSM state: 00 IDLE, 01 CAPTURE, 10 FROZEN.

Function
REQ-019 An event SHALL be the condition wb_valid_in && wb_reg_write_en_in on a rising edge while the state is CAPTURE.
REQ-020 The block SHALL compute class combinationally from wb_result_in at capture:
- exponent 0xFF and mantissa != 0 -> 11 (NaN)
- exponent 0xFF and mantissa == 0 -> 10 (infinity)
- bits[30:0] == 0 -> 01 (zero)
- otherwise -> 00
REQ-021 seq SHALL be an 8-bit counter that increments on every accepted event, wraps 0xFF -> 0x00, and is stored with each record.
REQ-022 Capture latency SHALL be 1 cycle: an event accepted at edge N makes trace_valid high after edge N when the FIFO was empty; there is no combinational bypass.
REQ-023 A pop SHALL occur on any edge where trace_valid && trace_ready; trace_data SHALL hold stable while trace_valid && !trace_ready.
REQ-024 A push and pop on the same edge SHALL both succeed, including when the FIFO is full, with trace_count unchanged.
REQ-025 The FSM SHALL have these transitions:
- IDLE -> CAPTURE on arm.
- CAPTURE -> IDLE on halt.
- CAPTURE -> FROZEN on an event that hits a full FIFO with no simultaneous pop, when STOP_ON_FULL = 1.
- FROZEN -> IDLE on clear only.
- arm SHALL be ignored in CAPTURE and FROZEN.
REQ-026 An event that hits a full FIFO with no pop SHALL not be written, SHALL increment drop_count, and SHALL not advance seq.
REQ-027 Draining by the host SHALL work in every state.
REQ-028 Pulse priority SHALL be clear > halt > arm; an event on the same edge as clear or halt SHALL be discarded.
REQ-029 Read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL be derived from the MSB comparison.
REQ-030 Events outside CAPTURE SHALL be ignored silently and SHALL not count as drops.

Reset
REQ-031 On reset the block SHALL set state IDLE, trace_valid 0, trace_count 0, drop_count 0, seq 0, and both pointers 0.
REQ-032 After reset, trace_data SHALL read as 0 until the first push.
REQ-033 Reset asserted mid-capture or mid-drain SHALL discard all FIFO contents within the same edge.
REQ-034 clear SHALL have the same effect as reset on the FIFO, counters and FSM.

Verification
REQ-035 The bench SHALL apply arm, then events rd=3 result=0x40490FD0 pc=0x00 and rd=20 result=0x7F800000 pc=0x2C with trace_ready=1, and SHALL check records seq0/class00/rd3 and seq1/class10/rd20 in order, each valid one cycle after capture.
REQ-036 The bench SHALL apply result 0x7FC00000 and then 0x80000000 and SHALL check class 11 and then class 01.
REQ-037 The bench SHALL, with trace_ready=0 and STOP_ON_FULL=1, apply 17 events and SHALL check trace_count=16, drop_count=1, state FROZEN, and that further events are ignored; it SHALL then drain 16 records with seq 0..15.
REQ-038 The bench SHALL, with STOP_ON_FULL=0 and the FIFO full, apply a simultaneous push and pop and SHALL check trace_count stays 16, drop_count 0, and that the new record carries seq 16.
REQ-039 The bench SHALL assert clear and halt on the same edge as an event in CAPTURE and SHALL check state IDLE, trace_count 0 and the event not stored.
REQ-040 The bench SHALL apply 300 events with a continuous drain and SHALL check that seq wraps 0xFF -> 0x00 and no drops occur.
